sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shared single-port SRAM arbiter for the IF and MEM pipeline stages.
// MEM has fixed priority; each access holds the strobes for ACCESS_CYCLES, then one recovery cycle.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_ready,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  input  logic        advance,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_data_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  localparam logic [1:0] CNT_INIT = 2'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       owner_mem;
  logic       op_write;
  logic       if_done;
  logic       mem_done;
  logic       mem_pend;
  logic       if_pend;

  assign mem_pend  = (mem_re | mem_we) & ~mem_done;
  assign if_pend   = if_req & ~if_done;
  assign stall_if  = if_pend;
  assign stall_mem = mem_pend;
  assign if_ready  = if_done;
  assign mem_ready = mem_done;

  // The advance clear is written first so a completion at the same edge overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      owner_mem   <= 1'b0;
      op_write    <= 1'b0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      if_data     <= 16'h0000;
      mem_rdata   <= 16'h0000;
      ram_addr    <= 16'h0000;
      ram_wdata   <= 16'h0000;
      ram_data_oe <= 1'b0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
    end else begin
      if (advance) begin
        if_done  <= 1'b0;
        mem_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (mem_pend) begin
            owner_mem   <= 1'b1;
            op_write    <= mem_we;
            ram_addr    <= mem_addr;
            ram_wdata   <= mem_wdata;
            cnt         <= CNT_INIT;
            ram_ce_n    <= 1'b0;
            ram_oe_n    <= mem_we;
            ram_we_n    <= ~mem_we;
            ram_data_oe <= mem_we;
            state       <= ACCESS;
          end else if (if_pend) begin
            owner_mem   <= 1'b0;
            op_write    <= 1'b0;
            ram_addr    <= if_addr;
            cnt         <= CNT_INIT;
            ram_ce_n    <= 1'b0;
            ram_oe_n    <= 1'b0;
            ram_we_n    <= 1'b1;
            ram_data_oe <= 1'b0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            if (owner_mem) begin
              if (!op_write) mem_rdata <= ram_rdata;
              mem_done <= 1'b1;
            end else begin
              if_data <= ram_rdata;
              if_done <= 1'b1;
            end
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_data_oe <= 1'b0;
            state       <= RECOVER;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (ACCESS_CYCLES 2, 1, 4) share stimulus and are
// compared every cycle against a timeline-based model, plus directed literal checks.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic        mem_re;
  logic        mem_we;
  logic        advance;
  logic [15:0] if_addr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] dut_if_data   [3];
  logic [15:0] dut_mem_rdata [3];
  logic [15:0] dut_ram_addr  [3];
  logic [15:0] dut_ram_wdata [3];
  logic        dut_if_ready  [3];
  logic        dut_mem_ready [3];
  logic        dut_stall_if  [3];
  logic        dut_stall_mem [3];
  logic        dut_data_oe   [3];
  logic        dut_ce_n      [3];
  logic        dut_oe_n      [3];
  logic        dut_we_n      [3];

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    sram_arbiter #(.ACCESS_CYCLES((k == 0) ? 2 : (k == 1) ? 1 : 4)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_data    (dut_if_data[k]),
      .if_ready   (dut_if_ready[k]),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (dut_mem_rdata[k]),
      .mem_ready  (dut_mem_ready[k]),
      .advance    (advance),
      .stall_if   (dut_stall_if[k]),
      .stall_mem  (dut_stall_mem[k]),
      .ram_addr   (dut_ram_addr[k]),
      .ram_wdata  (dut_ram_wdata[k]),
      .ram_rdata  (ram_rdata),
      .ram_data_oe(dut_data_oe[k]),
      .ram_ce_n   (dut_ce_n[k]),
      .ram_oe_n   (dut_oe_n[k]),
      .ram_we_n   (dut_we_n[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an access is a time window anchored at its grant edge, not a state machine.
  int          edge_n = 0;
  logic        m_busy      [3];
  int          m_g         [3];
  logic        m_own_mem   [3];
  logic        m_wr        [3];
  logic [15:0] m_addr      [3];
  logic [15:0] m_wdata     [3];
  logic        m_if_done   [3];
  logic        m_mem_done  [3];
  logic [15:0] m_if_data   [3];
  logic [15:0] m_mem_rdata [3];

  function automatic int ac_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k]      = 1'b0;
      m_g[k]         = 0;
      m_own_mem[k]   = 1'b0;
      m_wr[k]        = 1'b0;
      m_addr[k]      = 16'h0000;
      m_wdata[k]     = 16'h0000;
      m_if_done[k]   = 1'b0;
      m_mem_done[k]  = 1'b0;
      m_if_data[k]   = 16'h0000;
      m_mem_rdata[k] = 16'h0000;
    end
  endtask

  task automatic model_edge(input int k);
    logic mp, ip, nif, nmem;
    int   ac;
    ac   = ac_of(k);
    mp   = (mem_re | mem_we) & ~m_mem_done[k];
    ip   = if_req & ~m_if_done[k];
    nif  = advance ? 1'b0 : m_if_done[k];
    nmem = advance ? 1'b0 : m_mem_done[k];
    if (m_busy[k]) begin
      if (edge_n == m_g[k] + ac) begin
        if (m_own_mem[k]) begin
          nmem = 1'b1;
          if (!m_wr[k]) m_mem_rdata[k] = ram_rdata;
        end else begin
          nif = 1'b1;
          m_if_data[k] = ram_rdata;
        end
      end else if (edge_n == m_g[k] + ac + 1) begin
        m_busy[k] = 1'b0;
      end
    end else if (mp) begin
      m_busy[k]    = 1'b1;
      m_g[k]       = edge_n;
      m_own_mem[k] = 1'b1;
      m_wr[k]      = mem_we;
      m_addr[k]    = mem_addr;
      m_wdata[k]   = mem_wdata;
    end else if (ip) begin
      m_busy[k]    = 1'b1;
      m_g[k]       = edge_n;
      m_own_mem[k] = 1'b0;
      m_wr[k]      = 1'b0;
      m_addr[k]    = if_addr;
    end
    m_if_done[k]  = nif;
    m_mem_done[k] = nmem;
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      for (int k = 0; k < 3; k++) model_edge(k);
    end
  end

  task automatic check_output(input string name, input int k,
                              input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s inst%0d t=%0t: got %h want %h", name, k, $time, actual, expected);
    end
  endtask

  task automatic compare_inst(input int k);
    logic acc;
    acc = m_busy[k] && (edge_n >= m_g[k]) && (edge_n < m_g[k] + ac_of(k));
    check_output("if_data",   k, dut_if_data[k],   m_if_data[k]);
    check_output("if_ready",  k, 16'(dut_if_ready[k]),  16'(m_if_done[k]));
    check_output("mem_rdata", k, dut_mem_rdata[k], m_mem_rdata[k]);
    check_output("mem_ready", k, 16'(dut_mem_ready[k]), 16'(m_mem_done[k]));
    check_output("stall_if",  k, 16'(dut_stall_if[k]),  16'(if_req & ~m_if_done[k]));
    check_output("stall_mem", k, 16'(dut_stall_mem[k]), 16'((mem_re | mem_we) & ~m_mem_done[k]));
    check_output("ram_addr",  k, dut_ram_addr[k],  m_addr[k]);
    check_output("ram_ce_n",  k, 16'(dut_ce_n[k]),      16'(!acc));
    check_output("ram_oe_n",  k, 16'(dut_oe_n[k]),      16'(!(acc && !m_wr[k])));
    check_output("ram_we_n",  k, 16'(dut_we_n[k]),      16'(!(acc && m_wr[k])));
    check_output("data_oe",   k, 16'(dut_data_oe[k]),   16'(acc && m_wr[k]));
    if (acc && m_wr[k]) check_output("ram_wdata", k, dut_ram_wdata[k], m_wdata[k]);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) compare_inst(k);
  end

  // Inputs only ever change just after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic f_req, input logic [15:0] f_addr,
                                input logic re, input logic we, input logic [15:0] m_a,
                                input logic [15:0] m_d, input logic adv);
    if_req    = f_req;
    if_addr   = f_addr;
    mem_re    = re;
    mem_we    = we;
    mem_addr  = m_a;
    mem_wdata = m_d;
    advance   = adv;
  endtask

  task automatic settle();
    tick();
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    repeat (8) tick();
    advance = 1'b0;
  endtask

  int first_ready [3];

  initial begin
    rst = 1'b0;
    ram_rdata = 16'h0000;
    apply_stimulus(1'b1, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    model_reset();
    @(negedge clk);
    check_output("rst_stall_if",  0, 16'(dut_stall_if[0]),  16'h1);
    check_output("rst_stall_mem", 0, 16'(dut_stall_mem[0]), 16'h1);
    check_output("rst_ce_n",      0, 16'(dut_ce_n[0]),      16'h1);
    check_output("rst_ram_addr",  0, dut_ram_addr[0],       16'h0000);
    tick();
    rst = 1'b1;
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();

    // Fetch only, latency per instance.
    ram_rdata = 16'h1234;
    apply_stimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    first_ready = '{0, 0, 0};
    for (int e = 1; e <= 6; e++) begin
      tick();
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (dut_if_ready[k] && first_ready[k] == 0) first_ready[k] = e;
      if (e <= 2) begin
        check_output("fetch_ce_n", 0, 16'(dut_ce_n[0]), 16'h0);
        check_output("fetch_oe_n", 0, 16'(dut_oe_n[0]), 16'h0);
      end
      if (e == 1) check_output("fetch_addr", 0, dut_ram_addr[0], 16'h0040);
      if (e == 3) begin
        check_output("fetch_ready", 0, 16'(dut_if_ready[0]), 16'h1);
        check_output("fetch_data",  0, dut_if_data[0],       16'h1234);
        check_output("fetch_ce_hi", 0, 16'(dut_ce_n[0]),     16'h1);
        check_output("fetch_stall", 0, 16'(dut_stall_if[0]), 16'h0);
      end
    end
    check_output("latency", 0, 16'(first_ready[0]), 16'd3);
    check_output("latency", 1, 16'(first_ready[1]), 16'd2);
    check_output("latency", 2, 16'(first_ready[2]), 16'd5);
    settle();

    // Simultaneous fetch and load: MEM first.
    ram_rdata = 16'h5A5A;
    apply_stimulus(1'b1, 16'h0044, 1'b1, 1'b0, 16'h8000, 16'h0, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      @(negedge clk);
      if (e == 1) check_output("prio_addr", 0, dut_ram_addr[0], 16'h8000);
      if (e == 3) begin
        check_output("prio_mem_ready", 0, 16'(dut_mem_ready[0]), 16'h1);
        check_output("prio_if_wait",   0, 16'(dut_if_ready[0]),  16'h0);
        check_output("prio_rdata",     0, dut_mem_rdata[0],      16'h5A5A);
      end
      if (e == 5) check_output("prio_if_addr", 0, dut_ram_addr[0], 16'h0044);
      if (e == 7) check_output("prio_if_ready", 0, 16'(dut_if_ready[0]), 16'h1);
    end
    tick();
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    @(negedge clk);
    check_output("adv_if_clr",  0, 16'(dut_if_ready[0]),  16'h0);
    check_output("adv_mem_clr", 0, 16'(dut_mem_ready[0]), 16'h0);
    settle();

    // Store, then held load request must not re-access.
    ram_rdata = 16'h0F0F;
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h9000, 16'hBEEF, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      @(negedge clk);
      if (e <= 2) begin
        check_output("st_we_n",  0, 16'(dut_we_n[0]),    16'h0);
        check_output("st_oe",    0, 16'(dut_data_oe[0]), 16'h1);
        check_output("st_wdata", 0, dut_ram_wdata[0],    16'hBEEF);
      end
      if (e == 3) begin
        check_output("st_we_hi",  0, 16'(dut_we_n[0]),      16'h1);
        check_output("st_ready",  0, 16'(dut_mem_ready[0]), 16'h1);
        check_output("st_rdata",  0, dut_mem_rdata[0],      16'h5A5A);
      end
    end
    tick();
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h9000, 16'hBEEF, 1'b0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check_output("hold_ce_n",  0, 16'(dut_ce_n[0]),      16'h1);
      check_output("hold_ready", 0, 16'(dut_mem_ready[0]), 16'h1);
      tick();
    end
    settle();

    // Reset during the second access cycle.
    apply_stimulus(1'b1, 16'h00A0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    check_output("abort_ce_n",  0, 16'(dut_ce_n[0]),     16'h1);
    check_output("abort_oe_n",  0, 16'(dut_oe_n[0]),     16'h1);
    check_output("abort_addr",  0, dut_ram_addr[0],      16'h0000);
    check_output("abort_stall", 0, 16'(dut_stall_if[0]), 16'h1);
    tick();
    tick();
    rst = 1'b1;
    if_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_output("abort_no_ready", 0, 16'(dut_if_ready[0]), 16'h0);
      check_output("abort_no_data",  0, dut_if_data[0],       16'h0000);
      tick();
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                     16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
      ram_rdata = 16'($urandom);
      tick();
    end
    tick();
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
